// File: rtl/meas_seq_ctrl_if.sv
// Handshake bundle between the frequency-meter sequencer and its neighbours:
// edge-detect front end, gate counters, BCD converter and display driver.
interface meas_seq_ctrl_if;
  logic       run;
  logic       single;
  logic       sq_pose;
  logic       conv_done;
  logic       cnt_clr;
  logic       gate_open;
  logic       cnt_latch;
  logic       conv_start;
  logic       disp_load;
  logic       busy;
  logic       err_noedge;
  logic       err_conv;
  logic [2:0] state;

  // The sequencer side.
  modport master (
    input  run, single, sq_pose, conv_done,
    output cnt_clr, gate_open, cnt_latch, conv_start, disp_load,
           busy, err_noedge, err_conv, state
  );

  // The surrounding datapath / host side.
  modport slave (
    output run, single, sq_pose, conv_done,
    input  cnt_clr, gate_open, cnt_latch, conv_start, disp_load,
           busy, err_noedge, err_conv, state
  );
endinterface

// File: rtl/meas_seq_ctrl.sv
// Measurement sequencer for the 6 MHz frequency meter: arms on request, opens the
// gate on a square edge, closes it on the first edge after GATE_CYCLES, then latches, converts and displays.
module meas_seq_ctrl #(
  parameter int unsigned GATE_CYCLES  = 6_000_000,
  parameter int unsigned HOLD_CYCLES  = 3_000_000,
  parameter int unsigned CONV_TIMEOUT = 64
) (
  input  logic            clk_6M,
  input  logic            reset,
  meas_seq_ctrl_if.master bus
);

  localparam int TMR_W = 23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_OPEN  = 3'd2,
    S_CLOSE = 3'd3,
    S_LATCH = 3'd4,
    S_CONV  = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  // The timer counts down to zero, so each dwell loads its length minus one.
  localparam logic [TMR_W-1:0] GATE_LD = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] CONV_LD = TMR_W'(CONV_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);

  state_t            st;
  state_t            st_nxt;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_load;
  logic              tmr_zero;
  logic              entry;
  logic              fresh;
  logic              set_noedge;
  logic              set_conv;

  logic              cnt_clr_nxt;
  logic              gate_open_nxt;
  logic              cnt_latch_nxt;
  logic              conv_start_nxt;
  logic              disp_load_nxt;
  logic              busy_nxt;
  logic              err_noedge_nxt;
  logic              err_conv_nxt;

  assign tmr_zero = (tmr == '0);
  assign entry    = (st_nxt != st);

  // State register, shared down-timer and registered outputs.
  always_ff @(posedge clk_6M) begin
    if (reset) begin
      st             <= S_IDLE;
      tmr            <= '0;
      fresh          <= 1'b0;
      bus.cnt_clr    <= 1'b0;
      bus.gate_open  <= 1'b0;
      bus.cnt_latch  <= 1'b0;
      bus.conv_start <= 1'b0;
      bus.disp_load  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.err_noedge <= 1'b0;
      bus.err_conv   <= 1'b0;
      bus.state      <= S_IDLE;
    end else begin
      st             <= st_nxt;
      fresh          <= entry;
      if (entry) begin
        tmr <= tmr_load;
      end else if (!tmr_zero) begin
        tmr <= tmr - TMR_W'(1);
      end
      bus.cnt_clr    <= cnt_clr_nxt;
      bus.gate_open  <= gate_open_nxt;
      bus.cnt_latch  <= cnt_latch_nxt;
      bus.conv_start <= conv_start_nxt;
      bus.disp_load  <= disp_load_nxt;
      bus.busy       <= busy_nxt;
      bus.err_noedge <= err_noedge_nxt;
      bus.err_conv   <= err_conv_nxt;
      bus.state      <= st_nxt;
    end
  end

  // Next-state decision; edge and done qualifiers win over a simultaneous timeout.
  always_comb begin
    st_nxt     = st;
    set_noedge = 1'b0;
    set_conv   = 1'b0;
    case (st)
      S_IDLE: begin
        if (bus.run || bus.single) begin
          st_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.sq_pose) begin
          st_nxt = S_OPEN;
        end else if (tmr_zero) begin
          st_nxt     = S_IDLE;
          set_noedge = 1'b1;
        end
      end
      S_OPEN: begin
        if (tmr_zero) begin
          st_nxt = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (bus.sq_pose) begin
          st_nxt = S_LATCH;
        end else if (tmr_zero) begin
          st_nxt     = S_IDLE;
          set_noedge = 1'b1;
        end
      end
      S_LATCH: begin
        st_nxt = S_CONV;
      end
      S_CONV: begin
        // A done pulse coincident with conv_start belongs to an older conversion.
        if (bus.conv_done && !fresh) begin
          st_nxt = S_HOLD;
        end else if (tmr_zero) begin
          st_nxt   = S_IDLE;
          set_conv = 1'b1;
        end
      end
      S_HOLD: begin
        if (tmr_zero) begin
          st_nxt = bus.run ? S_ARM : S_IDLE;
        end
      end
      default: begin
        st_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state, so every port comes straight off a flop.
  always_comb begin
    cnt_clr_nxt    = entry && (st_nxt == S_ARM);
    gate_open_nxt  = (st_nxt == S_OPEN) || (st_nxt == S_CLOSE);
    cnt_latch_nxt  = (st_nxt == S_LATCH);
    conv_start_nxt = entry && (st_nxt == S_CONV);
    disp_load_nxt  = entry && (st_nxt == S_HOLD);
    busy_nxt       = (st_nxt != S_IDLE);
    err_noedge_nxt = !disp_load_nxt && (bus.err_noedge || set_noedge);
    err_conv_nxt   = !disp_load_nxt && (bus.err_conv || set_conv);
    tmr_load       = '0;
    case (st_nxt)
      S_ARM, S_OPEN, S_CLOSE: tmr_load = GATE_LD;
      S_CONV:                 tmr_load = CONV_LD;
      S_HOLD:                 tmr_load = HOLD_LD;
      default:                tmr_load = '0;
    endcase
  end

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Randomised bench for meas_seq_ctrl: a phase/age reference model is compared against
// every output each cycle, plus event-timing checks for the directed scenarios.
module tb_meas_seq_ctrl;

  localparam int G = 100;
  localparam int H = 20;
  localparam int T = 8;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_OPEN  = 2;
  localparam int P_CLOSE = 3;
  localparam int P_LATCH = 4;
  localparam int P_CONV  = 5;
  localparam int P_HOLD  = 6;

  logic clk_6M = 1'b0;
  logic reset  = 1'b1;

  meas_seq_ctrl_if bus ();

  meas_seq_ctrl #(
    .GATE_CYCLES (G),
    .HOLD_CYCLES (H),
    .CONV_TIMEOUT(T)
  ) dut (
    .clk_6M(clk_6M),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_6M = ~clk_6M;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: which phase of the measurement we are in and how long we have been there.
  typedef struct packed {
    int ph;
    int age;
    bit ne;
    bit ce;
  } mstate_t;

  mstate_t ms = '0;

  function automatic mstate_t ref_next(input mstate_t s, input bit rs, input bit run,
                                       input bit single, input bit sq, input bit done);
    mstate_t n;
    n = s;
    if (rs) begin
      n = '0;
      return n;
    end
    case (s.ph)
      P_IDLE:  if (run || single) n.ph = P_ARM;
      P_ARM:   if (sq) n.ph = P_OPEN;
               else if (s.age == G - 1) begin n.ph = P_IDLE; n.ne = 1'b1; end
      P_OPEN:  if (s.age == G - 1) n.ph = P_CLOSE;
      P_CLOSE: if (sq) n.ph = P_LATCH;
               else if (s.age == G - 1) begin n.ph = P_IDLE; n.ne = 1'b1; end
      P_LATCH: n.ph = P_CONV;
      P_CONV:  if (done && s.age >= 1) n.ph = P_HOLD;
               else if (s.age == T - 1) begin n.ph = P_IDLE; n.ce = 1'b1; end
      P_HOLD:  if (s.age == H - 1) n.ph = run ? P_ARM : P_IDLE;
      default: n.ph = P_IDLE;
    endcase
    if (n.ph == P_HOLD && s.ph != P_HOLD) begin
      n.ne = 1'b0;
      n.ce = 1'b0;
    end
    n.age = (n.ph == s.ph) ? s.age + 1 : 0;
    return n;
  endfunction

  always @(posedge clk_6M) begin
    cyc <= cyc + 1;
    ms  <= ref_next(ms, reset, bus.run, bus.single, bus.sq_pose, bus.conv_done);
  end

  function automatic logic [10:0] ref_vec();
    return {3'(ms.ph), ms.ph != P_IDLE, ms.ce, ms.ne,
            (ms.ph == P_HOLD) && (ms.age == 0), (ms.ph == P_CONV) && (ms.age == 0),
            ms.ph == P_LATCH, (ms.ph == P_OPEN) || (ms.ph == P_CLOSE),
            (ms.ph == P_ARM) && (ms.age == 0)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.state, bus.busy, bus.err_conv, bus.err_noedge, bus.disp_load,
            bus.conv_start, bus.cnt_latch, bus.gate_open, bus.cnt_clr};
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Event log of the DUT outputs, written only by step().
  int gate_rise = -1, gate_len = 0, n_gate = 0;
  int last_clr = -1, n_clr = 0, last_latch = -1, last_start = -1;
  int last_disp = -1, n_disp = 0, busy_fall = -1;
  bit prev_gate = 1'b0, prev_busy = 1'b0;

  // Stimulus generators.
  bit sq_on = 1'b0;
  int sq_per = 10, sq_cnt = 0;
  int done_delay = 0, pend = 0;
  bit done_noise = 1'b0;

  task automatic step();
    @(negedge clk_6M);
    check("outs", longint'(dut_vec()), longint'(ref_vec()));
    if (bus.gate_open && !prev_gate) begin gate_rise = cyc; gate_len = 0; n_gate++; end
    if (bus.gate_open) gate_len++;
    if (bus.cnt_clr) begin last_clr = cyc; n_clr++; end
    if (bus.cnt_latch) last_latch = cyc;
    if (bus.conv_start) last_start = cyc;
    if (bus.disp_load) begin last_disp = cyc; n_disp++; end
    if (!bus.busy && prev_busy) busy_fall = cyc;
    prev_gate = bus.gate_open;
    prev_busy = bus.busy;

    bus.conv_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) bus.conv_done = 1'b1;
    end
    if (bus.conv_start && done_delay > 0) pend = done_delay;
    if (done_noise && $urandom_range(0, 15) == 0) bus.conv_done = 1'b1;

    bus.sq_pose = 1'b0;
    if (sq_on) begin
      if (sq_cnt == 0) begin
        bus.sq_pose = 1'b1;
        sq_cnt = sq_per - 1;
      end else begin
        sq_cnt--;
      end
    end
    bus.single = 1'b0;
  endtask

  task automatic wait_idle(input int since, input int bound, input string tag);
    int k;
    k = 0;
    while (!(busy_fall > since) && k < bound) begin
      step();
      k++;
    end
    check(tag, longint'(busy_fall > since), 1);
  endtask

  initial begin
    int c, k, t0, g0, d0, cl0;
    bus.run = 1'b0; bus.single = 1'b0; bus.sq_pose = 1'b0; bus.conv_done = 1'b0;

    // Reset held for three cycles, then quiet.
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    check("rst_state", longint'(bus.state), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_outs", longint'(dut_vec()), 0);

    // Single request with no square edges: ARM times out.
    g0 = n_gate;
    step(); c = cyc; bus.single = 1'b1;
    wait_idle(c, 400, "noedge_idle");
    check("noedge_arm_len", busy_fall - c, G + 1);
    check("noedge_clr", last_clr, c + 1);
    check("noedge_err", longint'(bus.err_noedge), 1);
    check("noedge_no_gate", n_gate - g0, 0);

    // Good gate but the converter never answers.
    d0 = n_disp;
    done_delay = 0;
    sq_on = 1'b1; sq_per = $urandom_range(5, 20); sq_cnt = $urandom_range(0, sq_per - 1);
    step(); c = cyc; bus.single = 1'b1;
    wait_idle(c, 600, "conv_to_idle");
    check("conv_to_len", busy_fall - last_start, T);
    check("conv_to_err", longint'(bus.err_conv), 1);
    check("conv_to_noedge_sticky", longint'(bus.err_noedge), 1);
    check("conv_to_no_disp", n_disp - d0, 0);
    sq_on = 1'b0;
    repeat (3) step();

    // Full single measurement, square period 10, done three cycles after conv_start.
    cl0 = n_clr;
    k = $urandom_range(0, 9);
    step(); c = cyc; bus.single = 1'b1;
    sq_on = 1'b1; sq_per = 10; sq_cnt = k; done_delay = 3;
    t0 = c + 1 + k;
    wait_idle(c, 600, "meas_idle");
    check("meas_clr_cyc", last_clr, c + 1);
    check("meas_clr_once", n_clr - cl0, 1);
    check("meas_gate_rise", gate_rise, t0 + 1);
    check("meas_gate_len", gate_len, 110);
    check("meas_latch", last_latch, t0 + 111);
    check("meas_start", last_start, t0 + 112);
    check("meas_disp", last_disp, t0 + 116);
    check("meas_hold_end", busy_fall, t0 + 136);
    check("meas_err_clear", longint'({bus.err_noedge, bus.err_conv}), 0);
    sq_on = 1'b0;
    repeat (3) step();

    // Continuous run; drop run during the second OPEN.
    g0 = n_gate; d0 = n_disp;
    sq_on = 1'b1; sq_per = $urandom_range(6, 15); sq_cnt = 0;
    done_delay = $urandom_range(1, T - 1);
    step(); c = cyc; bus.run = 1'b1;
    k = 0;
    while (n_gate - g0 < 2 && k < 1000) begin step(); k++; end
    check("run_second_gate", n_gate - g0, 2);
    bus.run = 1'b0;
    wait_idle(c, 1000, "run_idle");
    check("run_n_disp", n_disp - d0, 2);
    check("run_n_gate", n_gate - g0, 2);

    // Third run aborted by reset in the middle of OPEN.
    g0 = n_gate;
    step(); bus.run = 1'b1;
    k = 0;
    while (n_gate == g0 && k < 400) begin step(); k++; end
    check("rst_run_gate", n_gate - g0, 1);
    repeat ($urandom_range(1, 50)) step();
    reset = 1'b1; bus.run = 1'b0;
    step();
    check("rst_mid_state", longint'(bus.state), 0);
    check("rst_mid_gate", longint'(bus.gate_open), 0);
    check("rst_mid_busy", longint'(bus.busy), 0);
    reset = 1'b0;
    sq_on = 1'b0;

    // Random soak against the reference model.
    done_noise = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 199) == 0) bus.run = ~bus.run;
      bus.single = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 299) == 0) begin
        sq_on = ~sq_on; sq_per = $urandom_range(3, 60); sq_cnt = 0;
      end
      if ($urandom_range(0, 99) == 0) done_delay = $urandom_range(0, 10);
    end
    reset = 1'b1;
    step();
    check("final_reset", longint'(dut_vec()), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
